// File: rtl/ppm_pkg.sv
// Shared 4-PPM line constants and decoder FSM state type; the encoder uses the same constants.
package ppm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2
  } ppm_state_e;

  localparam int PPM_SLOTS        = 4;
  localparam int PPM_SYM_PER_BYTE = 4;
  localparam int PPM_LEN_SYMS     = 2;

  localparam logic [3:0] PPM_SYNC_PAT = 4'b1111;

endpackage

// File: rtl/ppm_sym_demod.sv
// 4-PPM symbol demodulator: counts slots, latches the pulse position and flags
// symbols that do not carry exactly one pulse. Outputs are valid on the last slot.
module ppm_sym_demod
  import ppm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       din,
  output logic [1:0] sym,
  output logic       sym_done,
  output logic       sym_err
);

  logic [1:0] slot_cnt;
  logic [1:0] hi_cnt;
  logic [1:0] hi_idx;
  logic       last_slot;

  // Decision includes the slot being sampled now, so the symbol resolves on its own last edge.
  always_comb begin
    last_slot = (slot_cnt == 2'(PPM_SLOTS - 1));
    sym_done  = en && last_slot;
    sym_err   = sym_done && !((hi_cnt == 2'd0 && din) || (hi_cnt == 2'd1 && !din));
    sym       = din ? slot_cnt : hi_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      hi_cnt   <= '0;
      hi_idx   <= '0;
    end else if (!en || last_slot) begin
      slot_cnt <= '0;
      hi_cnt   <= '0;
      hi_idx   <= '0;
    end else begin
      slot_cnt <= slot_cnt + 2'd1;
      if (din) begin
        hi_idx <= slot_cnt;
        if (hi_cnt != 2'd2) hi_cnt <= hi_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/ppm_decoder.sv
// 4-PPM frame decoder: sync hunt, length field, payload bytes with valid strobe.
// Optional input synchronizer enabled by defining PPM_DEC_SYNC_EN.
module ppm_decoder
  import ppm_pkg::*;
#(
  parameter int SYNC_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Din,
  output logic [7:0] Dout,
  output logic       Dvalid,
  output logic [3:0] N,
  output logic       frame_start,
  output logic       frame_done,
  output logic       err,
  output logic [1:0] dbg_state
);

  logic din_s;

`ifdef PPM_DEC_SYNC_EN
  logic [1:0] sync_ff;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= '0;
    else        sync_ff <= {sync_ff[0], Din};
  end
  assign din_s = sync_ff[1];
`else
  assign din_s = Din;
`endif

  ppm_state_e          state;
  logic [SYNC_LEN-2:0] sync_sr;
  logic [SYNC_LEN-1:0] sync_win;
  logic                sync_hit;
  logic [1:0]          sym_cnt;
  logic [3:0]          byte_cnt;
  logic [5:0]          acc;
  logic [1:0]          sym;
  logic                sym_done;
  logic                sym_err;
  logic [3:0]          len_val;

  assign dbg_state = state;

  ppm_sym_demod u_demod (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state != IDLE),
    .din      (din_s),
    .sym      (sym),
    .sym_done (sym_done),
    .sym_err  (sym_err)
  );

  always_comb begin
    sync_win = {sync_sr, din_s};
    sync_hit = (sync_win == SYNC_LEN'(PPM_SYNC_PAT));
    len_val  = {acc[1:0], sym};
  end

  // sync_sr only shifts in IDLE and is zeroed on leaving it, so each hunt starts empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sync_sr     <= '0;
      sym_cnt     <= '0;
      byte_cnt    <= '0;
      acc         <= '0;
      Dout        <= '0;
      Dvalid      <= 1'b0;
      N           <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      Dvalid      <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_hit) begin
            state       <= LEN;
            frame_start <= 1'b1;
            sync_sr     <= '0;
            sym_cnt     <= '0;
            byte_cnt    <= '0;
            acc         <= '0;
          end else begin
            sync_sr <= sync_win[SYNC_LEN-2:0];
          end
        end
        LEN: begin
          if (sym_done) begin
            if (sym_err) begin
              err     <= 1'b1;
              sym_cnt <= '0;
              state   <= IDLE;
            end else if (sym_cnt == 2'(PPM_LEN_SYMS - 1)) begin
              N        <= len_val;
              byte_cnt <= len_val;
              sym_cnt  <= '0;
              if (len_val == 4'd0) begin
                frame_done <= 1'b1;
                state      <= IDLE;
              end else begin
                state <= DATA;
              end
            end else begin
              acc     <= {acc[3:0], sym};
              sym_cnt <= sym_cnt + 2'd1;
            end
          end
        end
        DATA: begin
          if (sym_done) begin
            if (sym_err) begin
              err     <= 1'b1;
              sym_cnt <= '0;
              state   <= IDLE;
            end else if (sym_cnt == 2'(PPM_SYM_PER_BYTE - 1)) begin
              Dout     <= {acc, sym};
              Dvalid   <= 1'b1;
              byte_cnt <= byte_cnt - 4'd1;
              sym_cnt  <= '0;
              if (byte_cnt == 4'd1) begin
                frame_done <= 1'b1;
                state      <= IDLE;
              end
            end else begin
              acc     <= {acc[3:0], sym};
              sym_cnt <= sym_cnt + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ppm_decoder.md
# ppm_decoder

Receive-side counterpart of the 4-PPM `encoder`. The block samples the serial PPM line one slot per `clk`, hunts for the frame sync pattern and recovers the 4-bit byte count. It then demodulates the payload back into bytes and presents each byte with a one-cycle valid strobe. It sits at the receiver front end and feeds the downstream byte sink, which has no backpressure.

## Interface
- `SYNC_LEN`, default 4: number of consecutive high slots that form the frame sync (fixed at 4 for the current line format).
- `clk`  in  1  slot clock; one PPM slot per rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Din`  in  1  serial PPM line; idle low.
- `Dout`  out  8  recovered byte; valid only while `Dvalid`=1.
- `Dvalid`  out  1  one-cycle strobe per recovered byte.
- `N`  out  4  byte count of the current frame; updated when the length field completes.
- `frame_start`  out  1  one-cycle pulse when sync is detected.
- `frame_done`  out  1  one-cycle pulse after the last byte (or after the length field when N=0).
- `err`  out  1  one-cycle pulse on an illegal symbol; the frame is aborted.

## Operation
- Line format, one bit per slot:
  - sync: 4 slots high;
  - length: 2 symbols, MSB pair first;
  - payload: N bytes of 4 symbols each, MSB pair first.
- Symbol: 4 slots with exactly one high. Value = index of the high slot (slot 0 → 2'b00, slot 3 → 2'b11).
- Frame length on the line = 4 + 8 + 16·N slots.
- FSM states: IDLE, LEN, DATA.
- IDLE:
  - A 4-bit sample shift register equal to 4'b1111 → go to LEN and pulse `frame_start`.
  - The slot counter and symbol counter are cleared on this transition.
- LEN:
  - Decode 2 symbols into `N`.
  - N=0 → pulse `frame_done` and go to IDLE.
  - Otherwise go to DATA with the byte counter = N.
- DATA:
  - Decode 4 symbols into a byte shift register, then pulse `Dvalid`.
  - Decrement the byte counter. At 0, pulse `frame_done` and go to IDLE.
- Symbol check at slot 3: if the high-slot count ≠ 1 (zero pulses or more than one), pulse `err`, drop the partial byte and go to IDLE.
  - `N` keeps its last value.
  - No `frame_done` is issued.
- Sync search restarts from an empty shift register after every return to IDLE. Trailing high slots of the aborted frame therefore do not count toward sync.
- Sync is detected only in IDLE. A run of 4 high slots inside LEN or DATA is always an illegal symbol.

## Timing
- Reset values:
  - `Dout`=8'h00, `N`=4'h0.
  - `Dvalid`, `frame_start`, `frame_done` and `err` = 0.
  - FSM in IDLE with all counters zero.
- `Din` is sampled on each rising edge of `clk`.
- `frame_start` is high for the cycle after the edge that samples the 4th sync slot.
- `N` updates at the edge sampling the last length slot; it is stable from the next cycle.
- `Dout`/`Dvalid` update at the edge sampling the 16th slot of the byte. `Dvalid` is high for exactly that following cycle; `Dout` holds until the next byte.
- Last byte of a frame: `frame_done` is asserted in the same cycle as its `Dvalid`.
- The first sync slot may directly follow the last slot of the previous frame. Back-to-back frames lose no slots.
- Reset asserted mid-frame: all outputs clear immediately; the partial frame is discarded.
- Latency from the last payload slot sampled to `Dvalid`: 1 cycle, or 3 cycles with the synchronizer.

## Configuration
- `PPM_DEC_SYNC_EN` defined:
  - `Din` passes through a 2-flop synchronizer (reset to 0) before the decoder.
  - All output timing shifts 2 cycles later.
- `PPM_DEC_SYNC_EN` undefined: `Din` feeds the sample register directly and is assumed synchronous to `clk`.

## Structure
- Shared package `ppm_pkg`:
  - FSM state enum (IDLE, LEN, DATA);
  - `PPM_SLOTS`=4, `PPM_SYM_PER_BYTE`=4, `PPM_LEN_SYMS`=2;
  - sync pattern 4'b1111.
  - The encoder uses the same constants.
- One sub-module, `ppm_sym_demod`:
  - counts slots 0..3 and latches the index of the high slot;
  - flags an illegal symbol;
  - emits a 2-bit symbol and a symbol-done strobe.
- The top level holds the FSM and the byte/length assembly.

## Test plan
- Frame N=4 with bytes C0, AA, DD, AE (C0 → slots 0001 1000 1000 1000) → `frame_start`, then `N`=4. Then 4 `Dvalid` pulses 16 cycles apart with `Dout`=C0, AA, DD, AE. `frame_done` comes with the 4th `Dvalid`. Total frame 76 slots.
- Frame N=0 (sync, then length slots 1000 1000) → `frame_start`, then `frame_done` 8 cycles later, no `Dvalid`.
- Second byte carries a symbol with slots 0110 → `err` pulse at that symbol's 4th slot. No second `Dvalid`, no `frame_done`. A following valid frame decodes correctly.
- Empty symbol 0000 in the length field → `err`, `N` unchanged, return to IDLE.
- Two N=1 frames back-to-back (bytes 5A, 3C) with no idle gap → two `frame_start`, `Dvalid` with 5A then 3C, two `frame_done`.
- `rst_n` pulsed low in the middle of the payload → all outputs 0 immediately. After release, the idle line and a new N=1 frame (byte 81) → `Dout`=81.
